// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC router defaults (flit width, buffer depth, packet length, yx address width)
package noc_pkg;
  localparam int NOC_FLIT_W  = 32;
  localparam int NOC_DEPTH   = 4;
  localparam int NOC_PKT_LEN = 4;
  localparam int NOC_ADDR_W  = 16;
endpackage

// File: rtl/flit_fifo.sv
// flit_fifo: first-word-fall-through flit storage with wrapping pointers and occupancy count
//   clk, reset (sync, active-low); push_i/data_i write the tail; pop_i advances the head;
//   data_o head flit; count_o occupancy; empty_o; push_ok_o/pop_ok_o accepted push/pop this cycle
module flit_fifo
  import noc_pkg::*;
#(
  parameter int FLIT_W = NOC_FLIT_W,
  parameter int DEPTH = NOC_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [FLIT_W-1:0] data_i,
  output logic [FLIT_W-1:0] data_o,
  output logic [CW-1:0]     count_o,
  output logic              empty_o,
  output logic              push_ok_o,
  output logic              pop_ok_o
);
  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    empty_o = count_q == '0;
    pop_ok_o = pop_i && !empty_o;
    // a full buffer still takes a push when the head leaves in the same cycle
    push_ok_o = push_i && (count_q != CW'(DEPTH) || pop_ok_o);
    wr_ptr_d = push_ok_o ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok_o ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = count_q + CW'(push_ok_o) - CW'(pop_ok_o);
    data_o = mem_q[rd_ptr_q];
    count_o = count_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset && push_ok_o) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/credit_input_buffer.sv
// credit_input_buffer: credit-based router input buffer feeding an arbiter
//   clk, reset (sync, active-low); link_valid_i/link_data_i upstream pushes; link_credit_o credit return;
//   arb_read_i pop; arb_empty_o, arb_address_o (yx header bits), arb_header_o, data_o head flit;
//   count_o occupancy; overflow_o/underflow_o sticky protocol errors
module credit_input_buffer
  import noc_pkg::*;
#(
  parameter int FLIT_W = NOC_FLIT_W,
  parameter int DEPTH = NOC_DEPTH,
  parameter int PKT_LEN = NOC_PKT_LEN,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(PKT_LEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  link_valid_i,
  input  logic [FLIT_W-1:0]     link_data_i,
  output logic                  link_credit_o,
  input  logic                  arb_read_i,
  output logic                  arb_empty_o,
  output logic [NOC_ADDR_W-1:0] arb_address_o,
  output logic                  arb_header_o,
  output logic [FLIT_W-1:0]     data_o,
  output logic [CW-1:0]         count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);
  logic push_ok, pop_ok, empty;
  logic [PW-1:0] pos_q, pos_d;
  logic credit_q, credit_d, over_q, over_d, under_q, under_d;
  flit_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(link_valid_i),
    .pop_i(arb_read_i),
    .data_i(link_data_i),
    .data_o(data_o),
    .count_o(count_o),
    .empty_o(empty),
    .push_ok_o(push_ok),
    .pop_ok_o(pop_ok)
  );
  always_comb begin
    credit_d = pop_ok;
    pos_d = pop_ok ? (pos_q == PW'(PKT_LEN - 1) ? '0 : pos_q + PW'(1)) : pos_q;
    over_d = over_q || (link_valid_i && !push_ok);
    under_d = under_q || (arb_read_i && empty);
    arb_empty_o = empty;
    arb_header_o = pos_q == '0 && !empty;
    arb_address_o = data_o[NOC_ADDR_W-1:0];
    link_credit_o = credit_q;
    overflow_o = over_q;
    underflow_o = under_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      pos_q <= '0;
      credit_q <= 1'b0;
      over_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      credit_q <= credit_d;
      over_q <= over_d;
      under_q <= under_d;
    end
  end
endmodule

// File: tb/tb_credit_input_buffer.sv
// tb_credit_input_buffer: scoreboard bench for credit_input_buffer
module tb_credit_input_buffer;
  localparam int FLIT_W = 32;
  localparam int DEPTH = 4;
  localparam int PKT_LEN = 4;
  logic clk = 0, reset = 0, link_valid_i = 0, arb_read_i = 0;
  logic [FLIT_W-1:0] link_data_i = '0;
  logic link_credit_o, arb_empty_o, arb_header_o, overflow_o, underflow_o;
  logic [15:0] arb_address_o;
  logic [FLIT_W-1:0] data_o;
  logic [2:0] count_o;
  credit_input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
    .clk(clk), .reset(reset), .link_valid_i(link_valid_i), .link_data_i(link_data_i),
    .link_credit_o(link_credit_o), .arb_read_i(arb_read_i), .arb_empty_o(arb_empty_o),
    .arb_address_o(arb_address_o), .arb_header_o(arb_header_o), .data_o(data_o),
    .count_o(count_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );
  always #5 clk = ~clk;
  logic [FLIT_W-1:0] sb[$];
  int errors = 0, checks = 0, pos = 0, up_cred = DEPTH, cred_seen = 0;
  bit exp_over = 0, exp_under = 0, prev_cred = 0;
  task automatic cycle(input logic v, input logic [FLIT_W-1:0] d, input logic rd, input logic rst_n);
    bit pop_ok, push_ok;
    logic [FLIT_W-1:0] e;
    logic [15:0] ea;
    link_valid_i = v;
    link_data_i = d;
    arb_read_i = rd;
    reset = rst_n;
    pop_ok = rst_n && rd && sb.size() != 0;
    push_ok = rst_n && v && (sb.size() < DEPTH || pop_ok);
    if (rst_n) begin
      if (rd && sb.size() == 0) exp_under = 1;
      if (v && !push_ok) exp_over = 1;
    end
    if (pop_ok) begin
      e = sb.pop_front();
      checks++;
      if (data_o !== e) begin errors++; $display("FAIL pop_data: got %h want %h", data_o, e); end
      pos = (pos + 1) % PKT_LEN;
    end
    if (push_ok) sb.push_back(d);
    up_cred += int'(prev_cred);
    if (push_ok) up_cred--;
    if (!rst_n) begin
      sb.delete();
      pos = 0;
      up_cred = DEPTH;
      exp_over = 0;
      exp_under = 0;
    end
    @(posedge clk);
    #1;
    link_valid_i = 0;
    arb_read_i = 0;
    reset = 1;
    checks++;
    if (link_credit_o !== pop_ok) begin errors++; $display("FAIL credit: got %b want %b", link_credit_o, pop_ok); end
    checks++;
    if (int'(count_o) !== sb.size()) begin errors++; $display("FAIL count: got %0d want %0d", count_o, sb.size()); end
    checks++;
    if (arb_empty_o !== (sb.size() == 0)) begin errors++; $display("FAIL empty: got %b want %b", arb_empty_o, sb.size() == 0); end
    checks++;
    if (arb_header_o !== (pos == 0 && sb.size() != 0)) begin errors++; $display("FAIL header: got %b want %b", arb_header_o, pos == 0 && sb.size() != 0); end
    checks++;
    if (overflow_o !== exp_over) begin errors++; $display("FAIL overflow: got %b want %b", overflow_o, exp_over); end
    checks++;
    if (underflow_o !== exp_under) begin errors++; $display("FAIL underflow: got %b want %b", underflow_o, exp_under); end
    checks++;
    if (int'(count_o) + int'(link_credit_o) + up_cred !== DEPTH) begin
      errors++;
      $display("FAIL credit_invariant: got %0d want %0d", int'(count_o) + int'(link_credit_o) + up_cred, DEPTH);
    end
    if (sb.size() != 0) begin
      e = sb[0];
      ea = e[15:0];
      checks++;
      if (data_o !== e) begin errors++; $display("FAIL head_data: got %h want %h", data_o, e); end
      checks++;
      if (arb_address_o !== ea) begin errors++; $display("FAIL address: got %h want %h", arb_address_o, ea); end
    end
    if (link_credit_o) cred_seen++;
    prev_cred = link_credit_o;
  endtask
  task automatic test_reset();
    cycle(1, 32'hFF, 1, 0);
    cycle(1, 32'hFE, 1, 0);
    checks++;
    if (count_o !== 3'd0 || arb_empty_o !== 1'b1) begin errors++; $display("FAIL reset_state: got count %0d empty %b want 0 1", count_o, arb_empty_o); end
    cycle(0, 0, 0, 1);
  endtask
  task automatic test_fill();
    for (int i = 0; i < 4; i++) cycle(1, 32'hA0 + i, 0, 1);
    checks++;
    if (count_o !== 3'd4 || data_o !== 32'hA0 || arb_header_o !== 1'b1 || arb_empty_o !== 1'b0) begin
      errors++;
      $display("FAIL fill: got count %0d data %h hdr %b empty %b want 4 a0 1 0", count_o, data_o, arb_header_o, arb_empty_o);
    end
  endtask
  task automatic test_drain();
    int c0 = cred_seen;
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 1);
    checks++;
    if (cred_seen - c0 !== 4) begin errors++; $display("FAIL drain_credits: got %0d want 4", cred_seen - c0); end
  endtask
  task automatic test_full_pushpop();
    for (int i = 0; i < 4; i++) cycle(1, 32'h10 + i, 0, 1);
    cycle(1, 32'hB0, 1, 1);
    checks++;
    if (count_o !== 3'd4 || overflow_o !== 1'b0) begin errors++; $display("FAIL full_pushpop: got count %0d ovf %b want 4 0", count_o, overflow_o); end
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1);
  endtask
  task automatic test_overflow_underflow();
    for (int i = 0; i < 4; i++) cycle(1, 32'h20 + i, 0, 1);
    cycle(1, 32'hC0, 0, 1);
    checks++;
    if (overflow_o !== 1'b1 || count_o !== 3'd4) begin errors++; $display("FAIL overflow_set: got ovf %b count %0d want 1 4", overflow_o, count_o); end
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1);
    checks++;
    if (underflow_o !== 1'b1 || link_credit_o !== 1'b0) begin errors++; $display("FAIL underflow_set: got unf %b credit %b want 1 0", underflow_o, link_credit_o); end
  endtask
  task automatic test_wrap();
    int c0 = cred_seen;
    cycle(1, 32'h40, 0, 1);
    for (int i = 1; i < 10; i++) cycle(1, 32'h40 + i, 1, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 1);
    checks++;
    if (cred_seen - c0 !== 10 || count_o !== 3'd0) begin errors++; $display("FAIL wrap: got credits %0d count %0d want 10 0", cred_seen - c0, count_o); end
  endtask
  task automatic test_reset_mid();
    int c0;
    for (int i = 0; i < 3; i++) cycle(1, 32'h60 + i, 0, 1);
    c0 = cred_seen;
    cycle(0, 0, 0, 0);
    checks++;
    if (count_o !== 3'd0 || arb_empty_o !== 1'b1 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got count %0d empty %b ovf %b unf %b want 0 1 0 0", count_o, arb_empty_o, overflow_o, underflow_o);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    checks++;
    if (cred_seen !== c0) begin errors++; $display("FAIL reset_mid_credits: got %0d want 0", cred_seen - c0); end
    cycle(1, 32'h70, 0, 1);
    checks++;
    if (arb_header_o !== 1'b1 || data_o !== 32'h70) begin errors++; $display("FAIL reset_mid_header: got hdr %b data %h want 1 70", arb_header_o, data_o); end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_pushpop();
    test_overflow_underflow();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/credit_input_buffer.md
CREDIT_INPUT_BUFFER -- requirements
Module: credit_input_buffer

Interface
REQ-001 SHALL have parameter FLIT_W, default 32, flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter PKT_LEN, default 4, flits per packet including the header; at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port link_valid_i, input, 1 bit: upstream flit push strobe.
REQ-007 SHALL have port link_data_i, input, FLIT_W bits: upstream flit.
REQ-008 SHALL have port link_credit_o, output, 1 bit: one-cycle credit-return pulse to upstream.
REQ-009 SHALL have port arb_read_i, input, 1 bit: pop strobe from the arbiter read output.
REQ-010 SHALL have port arb_empty_o, output, 1 bit: FIFO empty, driven to the arbiter.
REQ-011 SHALL have port arb_address_o, output, 16 bits: head flit [15:0], the yx destination header.
REQ-012 SHALL have port arb_header_o, output, 1 bit: the head flit is a packet header.
REQ-013 SHALL have port data_o, output, FLIT_W bits: head flit, first-word-fall-through.
REQ-014 SHALL have port count_o, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-015 SHALL have ports overflow_o and underflow_o, outputs, 1 bit each: sticky protocol-error flags.

Function
REQ-016 A push with count below DEPTH SHALL write link_data_i at the tail and raise occupancy by 1 at the next edge.
REQ-017 An arb_read_i pulse while not empty SHALL advance the head; data_o SHALL show the next entry one cycle later.
REQ-018 Simultaneous push and pop SHALL leave occupancy unchanged, including when count equals DEPTH (push accepted).
REQ-019 A push with count equal to DEPTH and no pop SHALL be dropped, leave state unchanged, and set overflow_o.
REQ-020 An arb_read_i pulse while empty SHALL be ignored and SHALL set underflow_o.
REQ-021 arb_empty_o SHALL equal (count_o == 0) combinationally from registered state; data_o and arb_address_o SHALL be don't-care while empty.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 link_credit_o SHALL pulse high for exactly one cycle, in the cycle after each accepted pop; one pulse per pop, never merged.
REQ-024 A flit-position counter SHALL count accepted pops modulo PKT_LEN.
REQ-025 arb_header_o SHALL be high only when the position counter is 0 and the FIFO is not empty.
REQ-026 Occupancy, plus credits in flight, plus upstream credits SHALL always equal DEPTH; the bench checks this invariant.

Reset
REQ-027 When reset is low at a clock edge, the block SHALL clear both pointers, count_o, the position counter, link_credit_o, overflow_o and underflow_o, and set arb_empty_o high.
REQ-028 Reset asserted mid-packet SHALL discard stored flits with no credit pulses.
REQ-029 Pushes and pops presented while reset is low SHALL be ignored.
REQ-030 Storage contents SHALL NOT require reset.

Structure
REQ-031 FLIT_W, DEPTH and PKT_LEN defaults and the 16-bit yx address width SHALL live in shared package noc_pkg.
REQ-032 Storage and pointers SHALL be one sub-module, flit_fifo; credit and header logic SHALL sit in the top.

Verification
REQ-033 Scenario: after reset, push 4 flits 0xA0..0xA3 on consecutive cycles -> count_o 4, arb_empty_o 0, data_o 0xA0, arb_header_o 1.
REQ-034 Scenario: pop the 4 flits on consecutive cycles -> data_o sequence 0xA0..0xA3; link_credit_o high on the 4 cycles after each pop; arb_header_o high for 0xA0 only.
REQ-035 Scenario: full FIFO, push 0xB0 together with a pop -> count_o stays 4, 0xB0 is stored, overflow_o stays 0.
REQ-036 Scenario: full FIFO, push 0xC0 without a pop -> overflow_o 1, contents unchanged. Separately, pop while empty -> underflow_o 1 and no credit pulse.
REQ-037 Scenario: 10 push/pop pairs with DEPTH=4 -> pointers wrap, order is preserved, 10 credit pulses are seen.
REQ-038 Scenario: reset low with 3 flits stored mid-packet -> count_o 0, arb_empty_o 1, position counter 0, no credit pulses.
